// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
// Size codes, FSM state encoding and the alignment check used by lsu_mem_ctrl.
package lsu_pkg;

  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Reserved size 00 behaves as a word.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lsb
  );
    logic m;
    case (size)
      SZ_HALF: m = lsb[0];
      SZ_BYTE: m = 1'b0;
      default: m = |lsb;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_ext.sv
// Combinational load extender: size, unsigned flag, raw memory data in;
// 32-bit sign/zero-extended data out. Sub-word fields arrive in the low bits.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  logic sb;
  logic sh;

  assign sb = ~uns & raw[7];
  assign sh = ~uns & raw[15];

  always_comb begin
    ext = raw;
    unique case (1'b1)
      (size == SZ_BYTE): ext = {{24{sb}}, raw[7:0]};
      (size == SZ_HALF): ext = {{16{sh}}, raw[15:0]};
      default:           ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one request at a time, one-cycle memory access,
// extended load data back on a valid/ready response channel.
// Ports: req_* request channel, resp_* response channel, mem_* memory port.
// Macro LSU_ALIGN_CHECK_EN enables misalignment detection and resp_err.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_ena,
  output logic              mem_wena,
  output logic [1:0]        mem_w_cs,
  output logic [1:0]        mem_r_cs,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  state_t state_nx;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [31:0]       ext;
  logic              mis;
  logic              accept;

  assign accept = (state == ST_IDLE) && req_valid;

`ifdef LSU_ALIGN_CHECK_EN
  logic err_q;

  assign mis = misaligned(req_size, req_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= mis;
    end
  end

  assign resp_err = err_q;
`else
  assign mis      = 1'b0;
  assign resp_err = 1'b0;
`endif

  lsu_load_ext u_ext (
    .size (size_q),
    .uns  (uns_q),
    .raw  (mem_rdata),
    .ext  (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state == ST_ACCESS) begin
        rdata_q <= we_q ? '0 : ext;
      end
    end
  end

  // Outputs decode only from state and latched fields.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_ena    = 1'b0;
    mem_wena   = 1'b0;
    mem_w_cs   = 2'b00;
    mem_r_cs   = 2'b00;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nx = mis ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_ena   = 1'b1;
        mem_wena  = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_w_cs  = we_q ? size_q : 2'b00;
        mem_r_cs  = we_q ? 2'b00 : size_q;
        state_nx  = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: randomized loads/stores against a
// byte-array reference memory, with a behavioural memory on the mem_* port.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ena;
  logic        mem_wena;
  logic [1:0]  mem_w_cs;
  logic [1:0]  mem_r_cs;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int rr_mode = 0;
  int ena_run = 0;

  logic [7:0]  dmem [0:255];
  logic [7:0]  gold [0:255];
  logic [32:0] exp_q [$];
  logic        stall_prev = 1'b0;
  logic [32:0] data_prev = '0;
  logic [7:0]  ra;

  lsu_mem_ctrl #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_ena      (mem_ena),
    .mem_wena     (mem_wena),
    .mem_w_cs     (mem_w_cs),
    .mem_r_cs     (mem_r_cs),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act,
                       input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory device on the mem_* port, little-endian, 256-byte window.
  always_comb begin
    ra = mem_addr[7:0];
    case (mem_r_cs)
      2'b11:   mem_rdata = {24'h0, dmem[ra]};
      2'b10:   mem_rdata = {16'h0, dmem[ra + 8'd1], dmem[ra]};
      default: mem_rdata = {dmem[ra + 8'd3], dmem[ra + 8'd2],
                            dmem[ra + 8'd1], dmem[ra]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_ena && mem_wena) begin
      case (mem_w_cs)
        2'b11: dmem[mem_addr[7:0]] <= mem_wdata[7:0];
        2'b10: begin
          dmem[mem_addr[7:0]]         <= mem_wdata[7:0];
          dmem[mem_addr[7:0] + 8'd1]  <= mem_wdata[15:8];
        end
        default: begin
          dmem[mem_addr[7:0]]         <= mem_wdata[7:0];
          dmem[mem_addr[7:0] + 8'd1]  <= mem_wdata[15:8];
          dmem[mem_addr[7:0] + 8'd2]  <= mem_wdata[23:16];
          dmem[mem_addr[7:0] + 8'd3]  <= mem_wdata[31:24];
        end
      endcase
    end
  end

  // Reference model.
  function automatic logic is_mis(input logic [1:0] size,
                                  input logic [31:0] addr);
`ifdef LSU_ALIGN_CHECK_EN
    if (size == 2'b11) return 1'b0;
    if (size == 2'b10) return addr[0];
    return addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] gold_load(input logic [1:0] size,
                                            input logic uns,
                                            input logic [31:0] addr);
    logic [7:0] a;
    int v;
    a = addr[7:0];
    if (size == 2'b11) begin
      v = gold[a];
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'b10) begin
      v = gold[a] + 256 * gold[a + 8'd1];
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = {gold[a + 8'd3], gold[a + 8'd2], gold[a + 8'd1], gold[a]};
    end
    return v;
  endfunction

  task automatic gold_store(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] d);
    int n;
    logic [7:0] a;
    a = addr[7:0];
    n = (size == 2'b11) ? 1 : (size == 2'b10) ? 2 : 4;
    for (int i = 0; i < n; i++) gold[a + 8'(i)] = 8'(d >> (8 * i));
  endtask

  task automatic issue(input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n = 0;
    logic m;
    logic [32:0] e;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", {32'h0, req_ready}, 33'd1);
      return;
    end
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    m = is_mis(size, addr);
    if (m) e = {1'b1, 32'h0};
    else if (we) begin
      e = {1'b0, 32'h0};
      gold_store(size, addr, wdata);
    end else e = {1'b0, gold_load(size, uns, addr)};
    @(posedge clk);
    #1 req_valid = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    check("access_ctl", {mem_ena, mem_wena, mem_w_cs, mem_r_cs, resp_valid},
          m ? {6'b0, 1'b1}
            : {1'b1, we, we ? size : 2'b00, we ? 2'b00 : size, 1'b0});
    if (!m) begin
      check("mem_addr", mem_addr, addr);
      check("mem_wdata", mem_wdata, wdata);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      1:       resp_ready = 1'b0;
      2:       resp_ready = 1'b1;
      default: resp_ready = ($urandom % 4) != 0;
    endcase
  end

  // Monitor: pops expected responses on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_ena) ena_run++;
      else begin
        if (ena_run != 0) check("ena_len", ena_run, 1);
        ena_run = 0;
      end
      if (mem_wena) check("wena_needs_ena", {32'h0, mem_ena}, 33'd1);
      if (resp_valid) begin
        check("resp_quiet", {req_ready, mem_ena}, 0);
        if (stall_prev) check("resp_stable", {resp_err, resp_rdata}, data_prev);
        if (resp_ready) begin
          if (exp_q.size() == 0) check("unexpected_resp", 1, 0);
          else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("resp_rdata", resp_rdata, e[31:0]);
            check("resp_err", {32'h0, resp_err}, {32'h0, e[32]});
          end
        end
      end
      stall_prev = resp_valid && !resp_ready;
      data_prev  = {resp_err, resp_rdata};
    end else begin
      stall_prev = 1'b0;
      ena_run    = 0;
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [7:0]  off;
    logic [31:0] a;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    resp_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {req_ready, resp_valid, resp_err, mem_ena, mem_wena,
                        mem_w_cs, mem_r_cs}, {1'b1, 8'b0});
    check("reset_rdata", resp_rdata, 0);
    check("reset_bus", {mem_addr | mem_wdata}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) issue(1'b1, SZ_WORD, 1'b0, BASE + 32'(4 * i), $urandom);

    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0);
    drain();
    check("word_model", gold_load(SZ_WORD, 1'b0, 32'h1001_0004), 32'hDEAD_BEEF);

    issue(1'b1, SZ_WORD, 1'b0, 32'h1001_0008, 32'h0000_00F0);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h1001_0008, 32'h0);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h1001_0008, 32'h0);

    issue(1'b1, SZ_HALF, 1'b0, 32'h1001_000E, 32'h0000_8001);
    issue(1'b0, SZ_HALF, 1'b0, 32'h1001_000E, 32'h0);
    issue(1'b0, SZ_HALF, 1'b1, 32'h1001_000C, 32'h0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_000C, 32'h0);
    issue(1'b0, 2'b00,   1'b1, 32'h1001_000C, 32'h0);

`ifdef LSU_ALIGN_CHECK_EN
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0002, 32'h0);
    issue(1'b1, SZ_HALF, 1'b0, 32'h1001_0001, 32'h5555_5555);
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0000, 32'h0);
`endif
    drain();

    rr_mode = 1;
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0);
    repeat (6) begin
      @(negedge clk);
      check("backpressure", {req_ready, resp_valid, mem_ena}, 3'b010);
    end
    rr_mode = 2;
    @(negedge clk);
    @(negedge clk);
    check("release_idle", {req_ready, resp_valid}, 2'b10);
    rr_mode = 0;
    drain();

    @(negedge clk);
    req_we    = 1'b1;
    req_size  = SZ_WORD;
    req_addr  = 32'h1001_0010;
    req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 check("rst_pre", {mem_ena, mem_wena}, 2'b11);
    rst_n = 1'b0;
    #1 check("rst_drop", {mem_ena, mem_wena, req_ready, resp_valid}, 4'b0010);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, SZ_WORD, 1'b0, 32'h1001_0010, 32'h0);
    drain();

    for (int i = 0; i < 150; i++) begin
      sz  = 2'($urandom);
      off = 8'($urandom);
      a   = BASE | {24'h0, off};
`ifdef LSU_ALIGN_CHECK_EN
      if ($urandom % 4 != 0)
`endif
      begin
        if (sz == 2'b10) a[0] = 1'b0;
        else if (sz != 2'b11) a[1:0] = 2'b00;
      end
      issue(1'($urandom), sz, 1'($urandom), a, $urandom);
    end
    rr_mode = 2;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
